// File: rtl/usb_toggle_ctrl_if.sv
// Bus between the USB serial interface engine / firmware and the DATA0/DATA1 toggle sequencer.
// The slave side is the sequencer; the master side drives tokens, packets and handshakes.
interface usb_toggle_ctrl_if #(
    parameter int NUM_ENDP = 2
);
    logic                tok_valid;
    logic [3:0]          tok_pid;
    logic [3:0]          tok_endp;
    logic                out_done;
    logic [3:0]          out_pid;
    logic                in_done;
    logic                rx_active;
    logic                hs_valid;
    logic [3:0]          hs_pid;
    logic                clr_setup;
    logic [NUM_ENDP-1:0] toggle_clr;
    logic [3:0]          data_pid;
    logic                out_seq_ok;
    logic                in_acked;
    logic                in_retry;
    logic                hs_busy;
    logic                setup_pend;
    logic [1:0]          ctl_stage;

    modport slave (
        input  tok_valid, tok_pid, tok_endp, out_done, out_pid, in_done, rx_active,
               hs_valid, hs_pid, clr_setup, toggle_clr,
        output data_pid, out_seq_ok, in_acked, in_retry, hs_busy, setup_pend, ctl_stage
    );

    modport master (
        output tok_valid, tok_pid, tok_endp, out_done, out_pid, in_done, rx_active,
               hs_valid, hs_pid, clr_setup, toggle_clr,
        input  data_pid, out_seq_ok, in_acked, in_retry, hs_busy, setup_pend, ctl_stage
    );
endinterface

// File: rtl/usb_toggle_ctrl.sv
// USB transaction sequencer: per-endpoint DATA0/DATA1 toggles, duplicate OUT detection,
// IN handshake timeout and EP0 control-stage tracking.
module usb_toggle_ctrl #(
    parameter int NUM_ENDP   = 2,
    parameter int HS_TIMEOUT = 48
) (
    input  logic               clk,
    input  logic               usb_reset,
    usb_toggle_ctrl_if.slave   sie
);
    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_WAIT_HS = 1'b1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETUP    = 2'd1;
    localparam logic [1:0] ST_DATA_IN  = 2'd2;
    localparam logic [1:0] ST_DATA_OUT = 2'd3;

    localparam int             CNT_W    = $clog2(HS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HS_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HS_TIMEOUT);

    logic [0:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_ENDP-1:0] toggle_q, toggle_d;
    logic [1:0]          stage_q, stage_d;
    logic                setup_q, setup_d;
    logic                acked_q, acked_d;
    logic                retry_q, retry_d;
    logic [3:0]          cur_pid_q, cur_pid_d;
    logic [3:0]          cur_endp_q, cur_endp_d;
    logic                rx_active_q;

    logic [NUM_ENDP-1:0] sel;
    logic [NUM_ENDP-1:0] flip;
    logic                cur_tog;
    logic                endp_ok;
    logic                ep0;
    logic                seq_ok;
    logic                hs_ack;
    logic                rx_fall;
    logic                setup_rx;
    logic                out_ok;
    logic [3:0]          data_pid;

    always_comb begin
        sel     = '0;
        cur_tog = 1'b0;
        for (int i = 0; i < NUM_ENDP; i++) begin
            if (cur_endp_q == 4'(i)) begin
                sel[i]  = 1'b1;
                cur_tog = toggle_q[i];
            end
        end
    end

    assign endp_ok  = ({1'b0, cur_endp_q} < 5'(NUM_ENDP));
    assign ep0      = (cur_endp_q == 4'd0);
    assign hs_ack   = sie.hs_valid && (sie.hs_pid == PID_ACK);
    assign rx_fall  = rx_active_q && !sie.rx_active;
    assign setup_rx = sie.out_done && endp_ok && (cur_pid_q == PID_SETUP);
    assign out_ok   = sie.out_done && endp_ok && (cur_pid_q == PID_OUT) && seq_ok;

    // EP0 status stage after a control write or no-data request always carries DATA1.
    always_comb begin
        data_pid = PID_DATA0;
        seq_ok   = 1'b0;
        if (endp_ok) begin
            if (cur_tog || (ep0 && (stage_q == ST_DATA_OUT || stage_q == ST_SETUP)))
                data_pid = PID_DATA1;
            if (cur_pid_q == PID_SETUP)
                seq_ok = (sie.out_pid == PID_DATA0);
            else
                seq_ok = (sie.out_pid == (cur_tog ? PID_DATA1 : PID_DATA0)) ||
                         (ep0 && stage_q == ST_DATA_IN && sie.out_pid == PID_DATA1);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        toggle_d   = toggle_q;
        stage_d    = stage_q;
        setup_d    = setup_q;
        cur_pid_d  = cur_pid_q;
        cur_endp_d = cur_endp_q;
        acked_d    = 1'b0;
        retry_d    = 1'b0;
        flip       = '0;

        if (sie.tok_valid) begin
            cur_pid_d  = sie.tok_pid;
            cur_endp_d = sie.tok_endp;
        end

        // A new token while waiting means the host gave up on our IN data.
        if (state_q == S_WAIT_HS) begin
            if (!sie.rx_active && cnt_q != CNT_MAX)
                cnt_d = cnt_q + CNT_W'(1);
            if (sie.tok_valid) begin
                retry_d = 1'b1;
                state_d = S_IDLE;
            end else if (hs_ack) begin
                acked_d = 1'b1;
                state_d = S_IDLE;
                if (endp_ok)
                    flip = sel;
                if (ep0 && stage_q == ST_SETUP)
                    stage_d = ST_DATA_IN;
                else if (ep0 && stage_q == ST_DATA_OUT)
                    stage_d = ST_IDLE;
            end else if (sie.hs_valid || cnt_q == CNT_LAST || rx_fall) begin
                retry_d = 1'b1;
                state_d = S_IDLE;
            end
        end else if (sie.in_done && endp_ok) begin
            state_d = S_WAIT_HS;
            cnt_d   = '0;
        end

        if (out_ok) begin
            flip = flip | sel;
            if (ep0 && stage_q == ST_SETUP)
                stage_d = ST_DATA_OUT;
            else if (ep0 && stage_q == ST_DATA_IN)
                stage_d = ST_IDLE;
        end

        if (setup_rx) begin
            stage_d = ST_SETUP;
            setup_d = 1'b1;
        end else if (sie.clr_setup) begin
            setup_d = 1'b0;
        end

        // Firmware clear has the final say over any flip or SETUP preset.
        for (int i = 0; i < NUM_ENDP; i++) begin
            if (sie.toggle_clr[i])
                toggle_d[i] = 1'b0;
            else if (i == 0 && setup_rx)
                toggle_d[i] = 1'b1;
            else if (flip[i])
                toggle_d[i] = ~toggle_q[i];
        end
    end

    always_ff @(posedge clk or posedge usb_reset) begin
        if (usb_reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            toggle_q    <= '0;
            stage_q     <= ST_IDLE;
            setup_q     <= 1'b0;
            acked_q     <= 1'b0;
            retry_q     <= 1'b0;
            cur_pid_q   <= 4'd0;
            cur_endp_q  <= 4'd0;
            rx_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            toggle_q    <= toggle_d;
            stage_q     <= stage_d;
            setup_q     <= setup_d;
            acked_q     <= acked_d;
            retry_q     <= retry_d;
            cur_pid_q   <= cur_pid_d;
            cur_endp_q  <= cur_endp_d;
            rx_active_q <= sie.rx_active;
        end
    end

    assign sie.data_pid   = data_pid;
    assign sie.out_seq_ok = seq_ok;
    assign sie.in_acked   = acked_q;
    assign sie.in_retry   = retry_q;
    assign sie.hs_busy    = (state_q == S_WAIT_HS);
    assign sie.setup_pend = setup_q;
    assign sie.ctl_stage  = stage_q;
endmodule

// File: tb/tb_usb_toggle_ctrl.sv
// Directed bench for usb_toggle_ctrl: a vector table for single-cycle behaviour plus
// hand-written sequences for handshake timing, reset and simultaneous-event corners.
module tb_usb_toggle_ctrl;
    localparam logic [3:0] P_OUT   = 4'b0001;
    localparam logic [3:0] P_IN    = 4'b1001;
    localparam logic [3:0] P_SETUP = 4'b1101;
    localparam logic [3:0] D0      = 4'b0011;
    localparam logic [3:0] D1      = 4'b1011;
    localparam logic [3:0] P_ACK   = 4'b0010;
    localparam logic [3:0] P_NAK   = 4'b1010;
    localparam logic [3:0] NONE    = 4'b0000;

    typedef struct {
        string      name;
        logic       tv;
        logic [3:0] tpid;
        logic [3:0] tendp;
        logic       od;
        logic [3:0] opid;
        logic       ind;
        logic       hv;
        logic [3:0] hpid;
        logic       clr;
        logic       exp_ok;
        logic [3:0] exp_dp;
        logic       exp_ack;
        logic       exp_rty;
        logic       exp_busy;
        logic       exp_sp;
        logic [1:0] exp_st;
    } vec_t;

    logic clk = 1'b0;
    logic usb_reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vecs[$];

    usb_toggle_ctrl_if #(.NUM_ENDP(2)) bus();

    usb_toggle_ctrl #(.NUM_ENDP(2), .HS_TIMEOUT(48)) dut (
        .clk       (clk),
        .usb_reset (usb_reset),
        .sie       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.tok_valid  = 1'b0;
        bus.tok_pid    = NONE;
        bus.tok_endp   = 4'd0;
        bus.out_done   = 1'b0;
        bus.out_pid    = NONE;
        bus.in_done    = 1'b0;
        bus.hs_valid   = 1'b0;
        bus.hs_pid     = NONE;
        bus.clr_setup  = 1'b0;
        bus.toggle_clr = 2'b00;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.tok_valid  = v.tv;
        bus.tok_pid    = v.tpid;
        bus.tok_endp   = v.tendp;
        bus.out_done   = v.od;
        bus.out_pid    = v.opid;
        bus.in_done    = v.ind;
        bus.hs_valid   = v.hv;
        bus.hs_pid     = v.hpid;
        bus.clr_setup  = v.clr;
        bus.toggle_clr = 2'b00;
    endtask

    task automatic do_reset();
        clear_inputs();
        bus.rx_active = 1'b0;
        usb_reset = 1'b1;
        tick();
        tick();
        usb_reset = 1'b0;
        tick();
    endtask

    task automatic token(input logic [3:0] pid, input logic [3:0] endp);
        clear_inputs();
        bus.tok_valid = 1'b1;
        bus.tok_pid   = pid;
        bus.tok_endp  = endp;
        tick();
        clear_inputs();
    endtask

    task automatic pulse_in_done();
        clear_inputs();
        bus.in_done = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic handshake(input logic [3:0] pid, input logic [1:0] clr);
        clear_inputs();
        bus.hs_valid   = 1'b1;
        bus.hs_pid     = pid;
        bus.toggle_clr = clr;
        tick();
        clear_inputs();
    endtask

    function automatic void add_vec(string name, logic tv, logic [3:0] tpid, logic [3:0] tendp,
                                    logic od, logic [3:0] opid, logic ind, logic hv, logic [3:0] hpid,
                                    logic clr, logic ok, logic [3:0] dp, logic ack, logic rty,
                                    logic busy, logic sp, logic [1:0] st);
        vec_t v;
        v.name = name; v.tv = tv; v.tpid = tpid; v.tendp = tendp; v.od = od; v.opid = opid;
        v.ind = ind; v.hv = hv; v.hpid = hpid; v.clr = clr; v.exp_ok = ok; v.exp_dp = dp;
        v.exp_ack = ack; v.exp_rty = rty; v.exp_busy = busy; v.exp_sp = sp; v.exp_st = st;
        vecs.push_back(v);
    endfunction

    initial begin
        int   cycles;
        logic seen;

        //        name          tv tpid    ep  od opid ind hv hpid  clr  ok dp  ack rty bsy sp st
        add_vec("out0_tok",    1, P_OUT,   0, 0, NONE, 0, 0, NONE, 0,   0, D0, 0, 0, 0, 0, 0);
        add_vec("out0_d0",     0, NONE,    0, 1, D0,   0, 0, NONE, 0,   1, D1, 0, 0, 0, 0, 0);
        add_vec("out0_dup",    0, NONE,    0, 1, D0,   0, 0, NONE, 0,   0, D1, 0, 0, 0, 0, 0);
        add_vec("out0_d1",     0, NONE,    0, 1, D1,   0, 0, NONE, 0,   1, D0, 0, 0, 0, 0, 0);
        add_vec("setup_tok",   1, P_SETUP, 0, 0, NONE, 0, 0, NONE, 0,   0, D0, 0, 0, 0, 0, 0);
        add_vec("setup_d0",    0, NONE,    0, 1, D0,   0, 0, NONE, 0,   1, D1, 0, 0, 0, 1, 1);
        add_vec("in0_tok",     1, P_IN,    0, 0, NONE, 0, 0, NONE, 0,   0, D1, 0, 0, 0, 1, 1);
        add_vec("in0_done",    0, NONE,    0, 0, NONE, 1, 0, NONE, 0,   0, D1, 0, 0, 1, 1, 1);
        add_vec("in0_wait",    0, NONE,    0, 0, NONE, 0, 0, NONE, 0,   0, D1, 0, 0, 1, 1, 1);
        add_vec("in0_ack",     0, NONE,    0, 0, NONE, 0, 1, P_ACK, 0,  0, D0, 1, 0, 0, 1, 2);
        add_vec("after_ack",   0, NONE,    0, 0, NONE, 0, 0, NONE, 0,   0, D0, 0, 0, 0, 1, 2);
        add_vec("stat_tok",    1, P_OUT,   0, 0, NONE, 0, 0, NONE, 0,   0, D0, 0, 0, 0, 1, 2);
        add_vec("stat_d1",     0, NONE,    0, 1, D1,   0, 0, NONE, 0,   1, D1, 0, 0, 0, 1, 0);
        add_vec("clr_setup",   0, NONE,    0, 0, NONE, 0, 0, NONE, 1,   0, D1, 0, 0, 0, 0, 0);
        add_vec("setup2_tok",  1, P_SETUP, 0, 0, NONE, 0, 0, NONE, 0,   0, D1, 0, 0, 0, 0, 0);
        add_vec("setup2_clr",  0, NONE,    0, 1, D0,   0, 0, NONE, 1,   1, D1, 0, 0, 0, 1, 1);
        add_vec("bad_tok",     1, P_OUT,   5, 0, NONE, 0, 0, NONE, 0,   0, D0, 0, 0, 0, 1, 1);
        add_vec("bad_d0",      0, NONE,    0, 1, D0,   0, 0, NONE, 0,   0, D0, 0, 0, 0, 1, 1);
        add_vec("bad_in_done", 0, NONE,    0, 0, NONE, 1, 0, NONE, 0,   0, D0, 0, 0, 0, 1, 1);
        add_vec("in0_tok2",    1, P_IN,    0, 0, NONE, 0, 0, NONE, 0,   0, D1, 0, 0, 0, 1, 1);
        add_vec("in0_done2",   0, NONE,    0, 0, NONE, 1, 0, NONE, 0,   0, D1, 0, 0, 1, 1, 1);
        add_vec("in0_nak",     0, NONE,    0, 0, NONE, 0, 1, P_NAK, 0,  0, D1, 0, 1, 0, 1, 1);
        add_vec("after_nak",   0, NONE,    0, 0, NONE, 0, 0, NONE, 0,   0, D1, 0, 0, 0, 1, 1);

        usb_reset = 1'b1;
        clear_inputs();
        bus.rx_active = 1'b0;
        tick();
        checkOutput("reset hs_busy",    {3'b0, bus.hs_busy},    4'd0);
        checkOutput("reset data_pid",   bus.data_pid,           D0);
        checkOutput("reset setup_pend", {3'b0, bus.setup_pend}, 4'd0);
        checkOutput("reset ctl_stage",  {2'b0, bus.ctl_stage},  4'd0);
        checkOutput("reset in_acked",   {3'b0, bus.in_acked},   4'd0);
        checkOutput("reset in_retry",   {3'b0, bus.in_retry},   4'd0);
        usb_reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput({vecs[i].name, " out_seq_ok"}, {3'b0, bus.out_seq_ok}, {3'b0, vecs[i].exp_ok});
            tick();
            clear_inputs();
            checkOutput({vecs[i].name, " data_pid"},   bus.data_pid,           vecs[i].exp_dp);
            checkOutput({vecs[i].name, " in_acked"},   {3'b0, bus.in_acked},   {3'b0, vecs[i].exp_ack});
            checkOutput({vecs[i].name, " in_retry"},   {3'b0, bus.in_retry},   {3'b0, vecs[i].exp_rty});
            checkOutput({vecs[i].name, " hs_busy"},    {3'b0, bus.hs_busy},    {3'b0, vecs[i].exp_busy});
            checkOutput({vecs[i].name, " setup_pend"}, {3'b0, bus.setup_pend}, {3'b0, vecs[i].exp_sp});
            checkOutput({vecs[i].name, " ctl_stage"},  {2'b0, bus.ctl_stage},  {2'b0, vecs[i].exp_st});
        end

        // IN on EP1, ACK ten clocks after in_done.
        do_reset();
        token(P_IN, 4'd1);
        checkOutput("ep1 first data_pid", bus.data_pid, D0);
        pulse_in_done();
        repeat (9) tick();
        checkOutput("ep1 busy before ack", {3'b0, bus.hs_busy}, 4'd1);
        handshake(P_ACK, 2'b00);
        checkOutput("ep1 in_acked", {3'b0, bus.in_acked}, 4'd1);
        checkOutput("ep1 no retry", {3'b0, bus.in_retry}, 4'd0);
        checkOutput("ep1 busy after ack", {3'b0, bus.hs_busy}, 4'd0);
        checkOutput("ep1 data_pid after ack", bus.data_pid, D1);
        tick();
        checkOutput("ep1 in_acked pulse ends", {3'b0, bus.in_acked}, 4'd0);

        // A token arriving during the handshake wait forces a retry and is still captured.
        pulse_in_done();
        tick();
        token(P_OUT, 4'd0);
        checkOutput("tok-in-wait retry", {3'b0, bus.in_retry}, 4'd1);
        checkOutput("tok-in-wait busy", {3'b0, bus.hs_busy}, 4'd0);
        checkOutput("tok-in-wait captured", bus.data_pid, D0);

        // Counter freezes while the host is transmitting.
        token(P_IN, 4'd1);
        checkOutput("ep1 pid before freeze", bus.data_pid, D1);
        pulse_in_done();
        bus.rx_active = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (bus.in_retry) seen = 1'b1;
        end
        checkOutput("freeze no retry", {3'b0, seen}, 4'd0);
        checkOutput("freeze still busy", {3'b0, bus.hs_busy}, 4'd1);
        bus.rx_active = 1'b0;
        handshake(P_ACK, 2'b00);
        checkOutput("freeze ack", {3'b0, bus.in_acked}, 4'd1);
        checkOutput("freeze ack data_pid", bus.data_pid, D0);

        // rx_active falling without a handshake packet.
        pulse_in_done();
        bus.rx_active = 1'b1;
        repeat (3) tick();
        bus.rx_active = 1'b0;
        tick();
        checkOutput("rx fall retry", {3'b0, bus.in_retry}, 4'd1);
        checkOutput("rx fall busy", {3'b0, bus.hs_busy}, 4'd0);
        checkOutput("rx fall data_pid", bus.data_pid, D0);

        // Timeout: retry lands exactly HS_TIMEOUT clocks after in_done.
        do_reset();
        token(P_IN, 4'd1);
        pulse_in_done();
        checkOutput("timeout busy", {3'b0, bus.hs_busy}, 4'd1);
        cycles = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (bus.in_retry) begin
                cycles = n;
                break;
            end
        end
        checkOutput("timeout cycle lo", 4'(cycles), 4'(48));
        checkOutput("timeout cycle hi", 4'(cycles >> 4), 4'(48 >> 4));
        checkOutput("timeout busy clear", {3'b0, bus.hs_busy}, 4'd0);
        checkOutput("timeout data_pid", bus.data_pid, D0);

        // toggle_clr together with an ACK flip: clear wins.
        pulse_in_done();
        handshake(P_ACK, 2'b10);
        checkOutput("clr+ack acked", {3'b0, bus.in_acked}, 4'd1);
        checkOutput("clr+ack data_pid", bus.data_pid, D0);
        pulse_in_done();
        handshake(P_ACK, 2'b00);
        checkOutput("plain ack data_pid", bus.data_pid, D1);

        // Reset in the middle of a handshake wait.
        pulse_in_done();
        tick();
        usb_reset = 1'b1;
        #1;
        checkOutput("midreset busy", {3'b0, bus.hs_busy}, 4'd0);
        checkOutput("midreset data_pid", bus.data_pid, D0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) usb_reset = 1'b0;
            tick();
            if (bus.in_retry || bus.in_acked) seen = 1'b1;
        end
        checkOutput("midreset no pulse", {3'b0, seen}, 4'd0);
        token(P_IN, 4'd1);
        checkOutput("midreset ep1 toggle", bus.data_pid, D0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
